// File: rtl/key_seq_gen.sv
// rtl/key_seq_gen.sv - timed press-sequence generator for a 9-bit key-driven LED counter
// Picks the shortest inc/dec path to the target and tracks the counter in a shadow register.
module key_seq_gen #(
  parameter int WIDTH     = 9,
  parameter int PRESS_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr,
  input  logic [WIDTH-1:0] target,
  output logic             key0_n,
  output logic             key1_n,
  output logic             key2_n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shadow
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, FIN} state_t;

  localparam logic [15:0]      PRESS_LD = 16'(PRESS_CYC - 1);
  localparam logic [15:0]      GAP_LD   = 16'(GAP_CYC - 1);
  localparam logic [WIDTH-1:0] HALF     = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] SEL_RST = 2'd0;
  localparam logic [1:0] SEL_INC = 2'd1;
  localparam logic [1:0] SEL_DEC = 2'd2;

  state_t           state, state_nx;
  logic [15:0]      timer, timer_nx;
  logic [WIDTH-1:0] remaining, remaining_nx;
  logic [WIDTH-1:0] shadow_nx;
  logic [WIDTH-1:0] diff;
  logic [1:0]       sel, sel_nx;
  logic [2:0]       key_q, key_nx;
  logic             busy_nx, done_nx;

  assign diff = target - shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      remaining <= '0;
      sel       <= SEL_RST;
      shadow    <= '0;
      key_q     <= 3'b111;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      remaining <= remaining_nx;
      sel       <= sel_nx;
      shadow    <= shadow_nx;
      key_q     <= key_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    timer_nx     = timer;
    remaining_nx = remaining;
    sel_nx       = sel;
    shadow_nx    = shadow;
    case (state)
      IDLE: begin
        // clr takes priority over a simultaneous start
        if (clr) begin
          sel_nx       = SEL_RST;
          remaining_nx = {{(WIDTH-1){1'b0}}, 1'b1};
          timer_nx     = PRESS_LD;
          state_nx     = PRESS;
        end else if (start) begin
          if (diff == '0) begin
            state_nx = FIN;
          end else begin
            timer_nx = PRESS_LD;
            state_nx = PRESS;
            if (diff <= HALF) begin
              sel_nx       = SEL_INC;
              remaining_nx = diff;
            end else begin
              sel_nx       = SEL_DEC;
              remaining_nx = {WIDTH{1'b0}} - diff;
            end
          end
        end
      end
      PRESS: begin
        if (timer == 16'd0) begin
          state_nx     = GAP;
          timer_nx     = GAP_LD;
          remaining_nx = remaining - {{(WIDTH-1){1'b0}}, 1'b1};
          case (sel)
            SEL_INC: shadow_nx = shadow + {{(WIDTH-1){1'b0}}, 1'b1};
            SEL_DEC: shadow_nx = shadow - {{(WIDTH-1){1'b0}}, 1'b1};
            default: shadow_nx = '0;
          endcase
        end else begin
          timer_nx = timer - 16'd1;
        end
      end
      GAP: begin
        if (timer == 16'd0) begin
          if (remaining == '0) begin
            state_nx = FIN;
          end else begin
            state_nx = PRESS;
            timer_nx = PRESS_LD;
          end
        end else begin
          timer_nx = timer - 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so key lines never glitch.
  always_comb begin
    key_nx  = 3'b111;
    busy_nx = (state_nx == PRESS) || (state_nx == GAP);
    done_nx = (state_nx == FIN);
    if (state_nx == PRESS) begin
      case (sel_nx)
        SEL_INC: key_nx = 3'b101;
        SEL_DEC: key_nx = 3'b011;
        default: key_nx = 3'b110;
      endcase
    end
  end

  assign key0_n = key_q[0];
  assign key1_n = key_q[1];
  assign key2_n = key_q[2];

endmodule

// File: tb/tb_key_seq_gen.sv
// tb/tb_key_seq_gen.sv - directed self-checking bench for key_seq_gen
// Cycle 1 is the cycle after the edge that samples the request.
module tb_key_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       clr;
  logic [8:0] target;
  logic       key0_n, key1_n, key2_n;
  logic       busy, done;
  logic [8:0] shadow;

  int n_pass  = 0;
  int n_total = 0;

  int pulses [3];
  int low_cyc;
  int busy_cyc;
  int done_cyc;
  int overlap;
  logic [8:0] sh5;

  // falling-edge counting model of the driven counter; power-up value is arbitrary
  logic [8:0] model = 9'h1AB;
  logic       p0 = 1'b1, p1 = 1'b1, p2 = 1'b1;

  key_seq_gen #(.WIDTH(9), .PRESS_CYC(4), .GAP_CYC(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .clr    (clr),
    .target (target),
    .key0_n (key0_n),
    .key1_n (key1_n),
    .key2_n (key2_n),
    .busy   (busy),
    .done   (done),
    .shadow (shadow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (p0 && !key0_n)      model <= 9'd0;
    else if (p1 && !key1_n) model <= model + 9'd1;
    else if (p2 && !key2_n) model <= model - 9'd1;
    p0 <= key0_n;
    p1 <= key1_n;
    p2 <= key2_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic run_req(input logic do_clr, input logic do_start, input logic [8:0] tgt,
                         input int inject_at, input int limit);
    logic q0, q1, q2;
    clr    = do_clr;
    start  = do_start;
    target = tgt;
    @(posedge clk); #1;
    clr   = 1'b0;
    start = 1'b0;
    pulses = '{0, 0, 0};
    low_cyc = 0; busy_cyc = 0; done_cyc = 0; overlap = 0; sh5 = 'x;
    q0 = 1'b1; q1 = 1'b1; q2 = 1'b1;
    for (int c = 1; c <= limit && done_cyc == 0; c++) begin
      if (!key0_n && q0) pulses[0]++;
      if (!key1_n && q1) pulses[1]++;
      if (!key2_n && q2) pulses[2]++;
      low_cyc += int'(!key0_n) + int'(!key1_n) + int'(!key2_n);
      if (int'(!key0_n) + int'(!key1_n) + int'(!key2_n) > 1) overlap++;
      if (busy) busy_cyc++;
      if (done) done_cyc = c;
      if (c == 5) sh5 = shadow;
      q0 = key0_n; q1 = key1_n; q2 = key2_n;
      if (c == inject_at) begin
        start  = 1'b1;
        clr    = 1'b1;
        target = 9'd0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      clr   = 1'b0;
    end
  endtask

  task automatic expect_req(input string tag, input int e0, input int e1, input int e2,
                            input int edone, input logic [8:0] esh);
    check({tag, ".key0_pulses"}, pulses[0], e0);
    check({tag, ".key1_pulses"}, pulses[1], e1);
    check({tag, ".key2_pulses"}, pulses[2], e2);
    check({tag, ".low_cycles"}, low_cyc, (e0 + e1 + e2) * 4);
    check({tag, ".done_cycle"}, done_cyc, edone);
    check({tag, ".busy_cycles"}, busy_cyc, edone - 1);
    check({tag, ".overlap"}, overlap, 0);
    check({tag, ".shadow"}, shadow, esh);
    check({tag, ".model"}, model, esh);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; target = 9'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.keys", {key2_n, key1_n, key0_n}, 3'b111);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.shadow", shadow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req(1'b1, 1'b0, 9'd0, 0, 50);
    expect_req("clr0", 1, 0, 0, 9, 9'd0);

    run_req(1'b0, 1'b1, 9'd5, 0, 100);
    expect_req("inc5", 0, 5, 0, 41, 9'd5);

    run_req(1'b1, 1'b0, 9'd0, 0, 50);
    run_req(1'b0, 1'b1, 9'd510, 0, 50);
    expect_req("dec510", 0, 0, 2, 17, 9'd510);
    check("dec510.wrap_shadow", sh5, 9'd511);

    run_req(1'b1, 1'b0, 9'd0, 0, 50);
    run_req(1'b0, 1'b1, 9'd256, 0, 2200);
    expect_req("tie256", 0, 256, 0, 2049, 9'd256);
    run_req(1'b0, 1'b1, 9'd255, 0, 50);
    expect_req("dec255", 0, 0, 1, 9, 9'd255);

    run_req(1'b1, 1'b0, 9'd0, 0, 50);
    run_req(1'b0, 1'b1, 9'd7, 0, 100);
    expect_req("inc7", 0, 7, 0, 57, 9'd7);
    run_req(1'b0, 1'b1, 9'd7, 0, 20);
    expect_req("noop7", 0, 0, 0, 1, 9'd7);

    run_req(1'b0, 1'b1, 9'd10, 3, 100);
    expect_req("busy_ignore", 0, 3, 0, 25, 9'd10);

    run_req(1'b1, 1'b1, 9'd20, 0, 50);
    expect_req("clr_wins", 1, 0, 0, 9, 9'd0);

    // abort during the third of five presses (cycles 17-20)
    start = 1'b1; target = 9'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (17) begin
      @(posedge clk); #1;
    end
    check("abort.key1_low", key1_n, 0);
    check("abort.shadow_pre", shadow, 9'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.keys", {key2_n, key1_n, key0_n}, 3'b111);
    check("abort.busy", busy, 0);
    check("abort.shadow", shadow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort.model", model, 9'd3);
    @(posedge clk); #1;
    run_req(1'b1, 1'b0, 9'd0, 0, 50);
    expect_req("abort_clr", 1, 0, 0, 9, 9'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
